adc_probe_monitor: RTL and testbench

//   Parametrised bench-top diagnostic for LTC2195-class ADC front ends: N_CH channels of W-bit samples.

---
 rtl/adc_probe_monitor.sv | 211 +++++++++++++++++++++
 tb/tb_adc_probe_monitor.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_probe_monitor.sv
// Purpose : ADC bring-up diagnostic: runtime bit probe, periodic ADC reset sequencer, heartbeat LED,
//           and per-window min/max capture on the selected channel.
// Latency : probe_out and window results one cycle after the qualifying sample; selection one cycle.
// Backpr. : none; adc_valid_in is a fire-and-forget qualifier, samples during ADC reset are dropped.
// Ports   : clk_in/rst_in (sync active-high) | adc_data_in[N_CH*W], adc_valid_in | sel_ch_in,
//           sel_bit_in, sel_load_in -> sel_err_out | auto_rst_en_in -> adc_rst_out, rst_led_out |
//           hb_led_out | probe_out | win_min_out, win_max_out, win_valid_out
module adc_probe_monitor #(
    parameter int N_CH       = 4,
    parameter int W          = 16,
    parameter int SIGNED     = 1,
    parameter int HB_DIV     = 5_000_000,
    parameter int RST_PERIOD = 600_000_000,
    parameter int RST_ON     = 570_000_000,
    parameter int WIN_LEN    = 1024,
    localparam int CW        = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int BW        = (W > 1) ? $clog2(W) : 1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [N_CH*W-1:0] adc_data_in,
    input  logic              adc_valid_in,
    input  logic [CW-1:0]     sel_ch_in,
    input  logic [BW-1:0]     sel_bit_in,
    input  logic              sel_load_in,
    input  logic              auto_rst_en_in,
    output logic              adc_rst_out,
    output logic              rst_led_out,
    output logic              hb_led_out,
    output logic              probe_out,
    output logic              sel_err_out,
    output logic [W-1:0]      win_min_out,
    output logic [W-1:0]      win_max_out,
    output logic              win_valid_out
);

    localparam int HW = (HB_DIV > 1) ? $clog2(HB_DIV) : 1;
    localparam int RW = (RST_PERIOD > 1) ? $clog2(RST_PERIOD) : 1;
    localparam int NW = $clog2(WIN_LEN + 1);

    localparam logic [HW-1:0] HB_LAST  = HW'(HB_DIV - 1);
    localparam logic [RW-1:0] RST_LAST = RW'(RST_PERIOD - 1);
    localparam logic [RW-1:0] RST_ON_C = RW'(RST_ON);
    localparam logic [NW-1:0] WIN_LAST = NW'(WIN_LEN);

    typedef enum logic {
        WIN_IDLE = 1'b0,
        WIN_ACC  = 1'b1
    } win_state_t;

    win_state_t      state_q, state_d;
    logic [HW-1:0]   hb_cnt_q, hb_cnt_d;
    logic            hb_q, hb_d;
    logic [RW-1:0]   rcnt_q, rcnt_d;
    logic            adc_rst_q, adc_rst_d;
    logic [CW-1:0]   ch_q, ch_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic            probe_q, probe_d;
    logic            sel_err_q, sel_err_d;
    logic [NW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    min_q, min_d;
    logic [W-1:0]    max_q, max_d;
    logic [W-1:0]    wmin_q, wmin_d;
    logic [W-1:0]    wmax_q, wmax_d;
    logic            wvld_q, wvld_d;

    logic            sel_ok;
    logic            restart;
    logic            accept;
    logic            counted;
    logic [W-1:0]    sample;
    logic [W-1:0]    nmin;
    logic [W-1:0]    nmax;
    logic [NW-1:0]   ncnt;

    function automatic logic less(input logic [W-1:0] a, input logic [W-1:0] b);
        if (SIGNED != 0) begin
            return $signed(a) < $signed(b);
        end
        return a < b;
    endfunction

    // Selected-channel sample, using the selection in force this cycle.
    always_comb begin
        sample = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (ch_q == CW'(c)) begin
                sample = adc_data_in[c*W +: W];
            end
        end
    end

    always_comb begin
        sel_ok  = (int'(sel_ch_in) < N_CH) && (int'(sel_bit_in) < W);
        restart = sel_load_in && sel_ok;
        // Samples arriving while the ADC is held in reset are meaningless.
        accept  = adc_valid_in && !adc_rst_q;
        // A selection change in the same cycle discards the sample from the window.
        counted = accept && !restart;
    end

    always_comb begin
        // Heartbeat
        hb_cnt_d = (hb_cnt_q == HB_LAST) ? '0 : hb_cnt_q + 1'b1;
        hb_d     = (hb_cnt_q == HB_LAST) ? ~hb_q : hb_q;

        // Periodic ADC reset sequencer
        if (auto_rst_en_in) begin
            rcnt_d    = (rcnt_q == RST_LAST) ? '0 : rcnt_q + 1'b1;
            adc_rst_d = (rcnt_q >= RST_ON_C);
        end else begin
            rcnt_d    = '0;
            adc_rst_d = 1'b0;
        end

        // Selection and probe
        ch_d      = restart ? sel_ch_in : ch_q;
        bit_d     = restart ? sel_bit_in : bit_q;
        sel_err_d = sel_load_in && !sel_ok;
        probe_d   = accept ? sample[bit_q] : probe_q;
    end

    // Window FSM next-state and outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        min_d   = min_q;
        max_d   = max_q;
        wmin_d  = wmin_q;
        wmax_d  = wmax_q;
        wvld_d  = 1'b0;
        nmin    = sample;
        nmax    = sample;
        ncnt    = NW'(1);

        if (state_q == WIN_ACC) begin
            nmin = less(sample, min_q) ? sample : min_q;
            nmax = less(max_q, sample) ? sample : max_q;
            ncnt = cnt_q + 1'b1;
        end

        if (adc_rst_q || restart) begin
            // Abort without publishing; the published outputs hold.
            state_d = WIN_IDLE;
            cnt_d   = '0;
            min_d   = '0;
            max_d   = '0;
        end else if (counted) begin
            if (ncnt == WIN_LAST) begin
                wmin_d  = nmin;
                wmax_d  = nmax;
                wvld_d  = 1'b1;
                state_d = WIN_IDLE;
                cnt_d   = '0;
                min_d   = '0;
                max_d   = '0;
            end else begin
                state_d = WIN_ACC;
                cnt_d   = ncnt;
                min_d   = nmin;
                max_d   = nmax;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= WIN_IDLE;
            hb_cnt_q  <= '0;
            hb_q      <= 1'b0;
            rcnt_q    <= '0;
            adc_rst_q <= 1'b0;
            ch_q      <= '0;
            bit_q     <= '0;
            probe_q   <= 1'b0;
            sel_err_q <= 1'b0;
            cnt_q     <= '0;
            min_q     <= '0;
            max_q     <= '0;
            wmin_q    <= '0;
            wmax_q    <= '0;
            wvld_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hb_cnt_q  <= hb_cnt_d;
            hb_q      <= hb_d;
            rcnt_q    <= rcnt_d;
            adc_rst_q <= adc_rst_d;
            ch_q      <= ch_d;
            bit_q     <= bit_d;
            probe_q   <= probe_d;
            sel_err_q <= sel_err_d;
            cnt_q     <= cnt_d;
            min_q     <= min_d;
            max_q     <= max_d;
            wmin_q    <= wmin_d;
            wmax_q    <= wmax_d;
            wvld_q    <= wvld_d;
        end
    end

    assign adc_rst_out   = adc_rst_q;
    assign rst_led_out   = ~adc_rst_q;
    assign hb_led_out    = hb_q;
    assign probe_out     = probe_q;
    assign sel_err_out   = sel_err_q;
    assign win_min_out   = wmin_q;
    assign win_max_out   = wmax_q;
    assign win_valid_out = wvld_q;

endmodule

// File: tb/tb_adc_probe_monitor.sv
// Purpose : self-checking bench for adc_probe_monitor (signed, unsigned and 3-channel instances).
// Latency : expectations are tagged with the clock edge at which they must be visible.
// Backpr. : none; the monitor pops per-cycle and per-window expectations independently.
module tb_adc_probe_monitor;

    localparam int N_CH = 2;
    localparam int W    = 8;
    localparam int HB   = 4;
    localparam int RP   = 20;
    localparam int RO   = 16;
    localparam int WL   = 4;

    logic        clk = 1'b0;
    logic        rst, en, vld, ld;
    logic [0:0]  ch;
    logic [2:0]  bt;
    logic [15:0] data;
    logic        e_ld;
    logic [1:0]  e_ch;
    logic [2:0]  e_bt;
    logic [23:0] e_data;

    logic       s_adc_rst, s_rst_led, s_hb, s_probe, s_err, s_wvld;
    logic [7:0] s_wmin, s_wmax;
    logic       u_adc_rst, u_rst_led, u_hb, u_probe, u_err, u_wvld;
    logic [7:0] u_wmin, u_wmax;
    logic       x_adc_rst, x_rst_led, x_hb, x_probe, x_err, x_wvld;
    logic [7:0] x_wmin, x_wmax;

    always #5 clk = ~clk;

    adc_probe_monitor #(.N_CH(N_CH), .W(W), .SIGNED(1), .HB_DIV(HB), .RST_PERIOD(RP),
                        .RST_ON(RO), .WIN_LEN(WL)) dut_s (
        .clk_in(clk), .rst_in(rst), .adc_data_in(data), .adc_valid_in(vld),
        .sel_ch_in(ch), .sel_bit_in(bt), .sel_load_in(ld), .auto_rst_en_in(en),
        .adc_rst_out(s_adc_rst), .rst_led_out(s_rst_led), .hb_led_out(s_hb),
        .probe_out(s_probe), .sel_err_out(s_err), .win_min_out(s_wmin),
        .win_max_out(s_wmax), .win_valid_out(s_wvld));

    adc_probe_monitor #(.N_CH(N_CH), .W(W), .SIGNED(0), .HB_DIV(HB), .RST_PERIOD(RP),
                        .RST_ON(RO), .WIN_LEN(WL)) dut_u (
        .clk_in(clk), .rst_in(rst), .adc_data_in(data), .adc_valid_in(vld),
        .sel_ch_in(ch), .sel_bit_in(bt), .sel_load_in(ld), .auto_rst_en_in(en),
        .adc_rst_out(u_adc_rst), .rst_led_out(u_rst_led), .hb_led_out(u_hb),
        .probe_out(u_probe), .sel_err_out(u_err), .win_min_out(u_wmin),
        .win_max_out(u_wmax), .win_valid_out(u_wvld));

    // Three channels so that an out-of-range channel request is expressible.
    adc_probe_monitor #(.N_CH(3), .W(W), .SIGNED(1), .HB_DIV(HB), .RST_PERIOD(RP),
                        .RST_ON(RO), .WIN_LEN(WL)) dut_x (
        .clk_in(clk), .rst_in(rst), .adc_data_in(e_data), .adc_valid_in(vld),
        .sel_ch_in(e_ch), .sel_bit_in(e_bt), .sel_load_in(e_ld), .auto_rst_en_in(en),
        .adc_rst_out(x_adc_rst), .rst_led_out(x_rst_led), .hb_led_out(x_hb),
        .probe_out(x_probe), .sel_err_out(x_err), .win_min_out(x_wmin),
        .win_max_out(x_wmax), .win_valid_out(x_wvld));

    typedef struct {
        int cyc;
        bit rst;
        bit adc_rst;
        bit hb;
        bit probe;
        bit sel_err;
        bit x_probe;
        bit x_err;
    } exp_t;

    typedef struct {
        int         cyc;
        logic [7:0] smin, smax, umin, umax;
    } win_t;

    exp_t expq[$];
    win_t winq[$];

    int compared   = 0;
    int mismatched = 0;
    int edge_n     = 0;

    // Reference model state
    int         phase;      // enabled edges since the sequencer was last cleared
    int         hbn;        // edges since reset
    bit         m_adc_rst, m_probe, x_m_probe;
    int         m_ch, m_bit, x_m_ch, x_m_bit;
    logic [7:0] win[$];

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_n, act, exp);
        end
    endtask

    // Monitor: sample one time unit after the active edge.
    always @(posedge clk) begin
        #1;
        if (expq.size() > 0 && expq[0].cyc == edge_n) begin
            exp_t e;
            e = expq.pop_front();
            chk("adc_rst", {31'd0, s_adc_rst}, {31'd0, e.adc_rst});
            chk("rst_led", {31'd0, s_rst_led}, {31'd0, !e.adc_rst});
            chk("hb_led", {31'd0, s_hb}, {31'd0, e.hb});
            chk("probe_s", {31'd0, s_probe}, {31'd0, e.probe});
            chk("probe_u", {31'd0, u_probe}, {31'd0, e.probe});
            chk("sel_err", {31'd0, s_err}, {31'd0, e.sel_err});
            chk("probe_x", {31'd0, x_probe}, {31'd0, e.x_probe});
            chk("sel_err_x", {31'd0, x_err}, {31'd0, e.x_err});
            if (e.rst) begin
                chk("rst_win_min", {24'd0, s_wmin}, 32'd0);
                chk("rst_win_max", {24'd0, s_wmax}, 32'd0);
            end
        end
        begin
            bit wv;
            wv = (winq.size() > 0 && winq[0].cyc == edge_n);
            chk("win_valid_s", {31'd0, s_wvld}, {31'd0, wv});
            chk("win_valid_u", {31'd0, u_wvld}, {31'd0, wv});
            if (wv) begin
                win_t w;
                w = winq.pop_front();
                chk("win_min_s", {24'd0, s_wmin}, {24'd0, w.smin});
                chk("win_max_s", {24'd0, s_wmax}, {24'd0, w.smax});
                chk("win_min_u", {24'd0, u_wmin}, {24'd0, w.umin});
                chk("win_max_u", {24'd0, u_wmax}, {24'd0, w.umax});
            end
        end
    end

    // Apply current inputs for one edge, predict the outputs after it, then wait.
    task automatic step();
        exp_t e;
        e.cyc = edge_n + 1;
        e.rst = rst;
        if (rst) begin
            phase = 0; hbn = 0; m_adc_rst = 0; m_probe = 0; x_m_probe = 0;
            m_ch = 0; m_bit = 0; x_m_ch = 0; x_m_bit = 0;
            win.delete();
            e.adc_rst = 0; e.hb = 0; e.probe = 0; e.sel_err = 0; e.x_probe = 0; e.x_err = 0;
        end else begin
            bit ok, x_ok, restart, accept;
            ok      = (int'(ch) < N_CH) && (int'(bt) < W);
            x_ok    = (int'(e_ch) < 3) && (int'(e_bt) < W);
            restart = ld && ok;
            accept  = vld && !m_adc_rst;
            if (accept) begin
                m_probe   = data[m_ch*W + m_bit];
                x_m_probe = e_data[x_m_ch*W + x_m_bit];
            end
            if (m_adc_rst || restart) begin
                win.delete();
            end else if (accept) begin
                win.push_back(data[m_ch*W +: W]);
                if (win.size() == WL) begin
                    win_t w;
                    byte  smn, smx, sv;
                    w.cyc = edge_n + 1;
                    smn = 127; smx = -128; w.umin = 8'hFF; w.umax = 8'h00;
                    foreach (win[i]) begin
                        sv = byte'(win[i]);
                        if (sv < smn) smn = sv;
                        if (sv > smx) smx = sv;
                        if (win[i] < w.umin) w.umin = win[i];
                        if (win[i] > w.umax) w.umax = win[i];
                    end
                    w.smin = 8'(smn);
                    w.smax = 8'(smx);
                    winq.push_back(w);
                    win.delete();
                end
            end
            if (restart) begin m_ch = int'(ch); m_bit = int'(bt); end
            if (e_ld && x_ok) begin x_m_ch = int'(e_ch); x_m_bit = int'(e_bt); end
            e.sel_err = ld && !ok;
            e.x_err   = e_ld && !x_ok;
            hbn++;
            e.hb = ((hbn / HB) % 2) == 1;
            m_adc_rst = en && ((phase % RP) >= RO);
            phase     = en ? phase + 1 : 0;
            e.adc_rst = m_adc_rst;
            e.probe   = m_probe;
            e.x_probe = x_m_probe;
        end
        expq.push_back(e);
        @(negedge clk);
        vld  = 1'b0;
        ld   = 1'b0;
        e_ld = 1'b0;
    endtask

    task automatic samp(input logic [7:0] v);
        vld    = 1'b1;
        data   = {v, 8'($urandom)};
        e_data = 24'($urandom);
        step();
    endtask

    task automatic load_main(input logic [0:0] c, input logic [2:0] b);
        ld = 1'b1; ch = c; bt = b;
        step();
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; vld = 1'b0; ld = 1'b0; ch = '0; bt = '0; data = '0;
        e_ld = 1'b0; e_ch = '0; e_bt = '0; e_data = '0;
        @(negedge clk);
        repeat (3) step();
        rst = 1'b0;

        // Sequencer and heartbeat from reset release with enable high.
        repeat (45) step();
        en = 1'b0;
        step();

        // Probe on channel 1 bit 7.
        load_main(1'b1, 3'd7);
        samp(8'h80); step();
        samp(8'h7F); step();

        // Rejected loads on the three-channel instance keep its selection.
        e_ld = 1'b1; e_ch = 2'd1; e_bt = 3'd5; step();
        e_ld = 1'b1; e_ch = 2'd3; e_bt = 3'd2; step();
        samp(8'h00); step();

        // Signed/unsigned min/max on a fresh window.
        load_main(1'b1, 3'd7);
        samp(8'h05); samp(8'hFB); step(); samp(8'h7F); samp(8'h80); step(); step();

        // Selection load coincident with the third sample restarts the window.
        samp(8'h10); samp(8'h20);
        vld = 1'b1; data = {8'h30, 8'h00}; ld = 1'b1; ch = 1'b1; bt = 3'd0; step();
        samp(8'h01); samp(8'h02); samp(8'h03); step(); samp(8'hF0); step(); step();

        // ADC reset assertion aborts windows; enable dropped while in reset.
        en = 1'b1;
        for (int i = 0; i < 40 && !m_adc_rst; i++) samp(8'($urandom));
        en = 1'b0;
        samp(8'h11); samp(8'h22);
        en = 1'b1;
        repeat (25) samp(8'($urandom));

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 499) == 0);
            en     = ($urandom_range(0, 63) != 0);
            vld    = ($urandom_range(0, 2) != 0);
            ld     = ($urandom_range(0, 15) == 0);
            ch     = 1'($urandom);
            bt     = 3'($urandom);
            case ($urandom_range(0, 3))
                0:       data = {8'h80, 8'($urandom)};
                1:       data = {8'h7F, 8'($urandom)};
                default: data = 16'($urandom);
            endcase
            e_ld   = ($urandom_range(0, 3) == 0);
            e_ch   = 2'($urandom);
            e_bt   = 3'($urandom);
            e_data = 24'($urandom);
            step();
        end
        rst = 1'b0; en = 1'b0;
        repeat (4) step();

        chk("win_queue_drained", winq.size(), 32'd0);
        chk("exp_queue_drained", expq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
